// File: rtl/id_ex_hazard_ctrl.sv
// rtl/id_ex_hazard_ctrl.sv - IF/ID, ID/EX and PC sequencing for load-use/RAW stalls, branch flush and mul/div freeze
// Optional EX operand forwarding selects are built when HAZ_FWD_EN is defined.
module id_ex_hazard_ctrl #(
  parameter int MD_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_use_rs_i,
  input  logic        id_use_rt_i,
  input  logic [4:0]  ex_rs_i,
  input  logic [4:0]  ex_rt_i,
  input  logic [4:0]  ex_dst_i,
  input  logic        ex_regwrite_i,
  input  logic        ex_memread_i,
  input  logic        ex_md_i,
  input  logic [4:0]  mem_dst_i,
  input  logic        mem_regwrite_i,
  input  logic [4:0]  wb_dst_i,
  input  logic        wb_regwrite_i,
  input  logic        branch_taken_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        idex_hold_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        md_busy_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  // The RUN cycle that first sees the mul/div already counts as one hold cycle.
  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 2);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hz_ld;
  logic       data_hz;

  assign hz_ld = ex_memread_i && (ex_dst_i != 5'd0) &&
                 ((id_use_rs_i && (id_rs_i == ex_dst_i)) ||
                  (id_use_rt_i && (id_rt_i == ex_dst_i)));

`ifdef HAZ_FWD_EN
  // EX/MEM holds the younger result, so it wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_regwrite_i && (mem_dst_i != 5'd0) && (mem_dst_i == src))
      fwd_sel = 2'b10;
    else if (wb_regwrite_i && (wb_dst_i != 5'd0) && (wb_dst_i == src))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  assign fwd_a_o = fwd_sel(ex_rs_i);
  assign fwd_b_o = fwd_sel(ex_rt_i);
  assign data_hz = hz_ld;

  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite_i;
`else
  logic hz_raw;

  // WB is not checked: the register file writes before it is read.
  assign hz_raw = (id_use_rs_i && (id_rs_i != 5'd0) &&
                   ((ex_regwrite_i  && (id_rs_i == ex_dst_i)) ||
                    (mem_regwrite_i && (id_rs_i == mem_dst_i)))) ||
                  (id_use_rt_i && (id_rt_i != 5'd0) &&
                   ((ex_regwrite_i  && (id_rt_i == ex_dst_i)) ||
                    (mem_regwrite_i && (id_rt_i == mem_dst_i))));

  assign fwd_a_o = 2'b00;
  assign fwd_b_o = 2'b00;
  assign data_hz = hz_ld || hz_raw;

  logic unused_fwd;
  assign unused_fwd = ^{ex_rs_i, ex_rt_i, wb_dst_i, wb_regwrite_i};
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    idex_hold_o   = 1'b0;
    md_busy_o     = 1'b0;

    case (state_q)
      RUN: begin
        if (branch_taken_i) begin
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
        end else if (ex_md_i) begin
          idex_hold_o  = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          state_d      = MD_BUSY;
          cnt_d        = MD_LOAD;
        end else if (data_hz) begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
        end
      end
      MD_BUSY: begin
        if (cnt_q != 8'd0) begin
          idex_hold_o  = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          md_busy_o    = 1'b1;
          cnt_d        = cnt_q - 8'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_o <= 16'd0;
    else if (!pc_write_o && (stall_cnt_o != 16'hFFFF))
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end

endmodule
